// File: rtl/obf_pkg.sv
// Shared types and constants for the OBF key loader: FSM states and per-gate select encodings.
package obf_pkg;

  localparam int unsigned SEL_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    COMMIT,
    LOCKED
  } state_e;

  localparam logic [SEL_W-1:0] SEL_PASS   = 2'b00;
  localparam logic [SEL_W-1:0] SEL_CONST1 = 2'b01;
  localparam logic [SEL_W-1:0] SEL_INV    = 2'b10;
  localparam logic [SEL_W-1:0] SEL_CONST0 = 2'b11;

endpackage

// File: rtl/obf_key_shadow.sv
// Shadow capture of an incoming key frame: LSB-first bit placement, bit counter and
// running parity over every accepted bit, including the trailing parity bit.
module obf_key_shadow #(
  parameter int unsigned KEY_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  output logic             full,
  output logic             parity_ok,
  output logic [KEY_W-1:0] data
);

  localparam int unsigned CNT_W = $clog2(KEY_W + 2);

  logic [CNT_W-1:0] bit_cnt;
  logic             par;

  // The parity bit advances the counter and parity but lands in no data slot.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      bit_cnt <= '0;
      data    <= '0;
      par     <= 1'b0;
    end else if (shift_en) begin
      for (int unsigned i = 0; i < KEY_W; i++) begin
        if (bit_cnt == CNT_W'(i)) data[i] <= din;
      end
      bit_cnt <= bit_cnt + CNT_W'(1);
      par     <= par ^ din;
    end
  end

  assign full      = (bit_cnt == CNT_W'(KEY_W));
  assign parity_ok = ~par;

endmodule

// File: rtl/obf_key_loader.sv
// Serial key-configuration controller: receives a parity-protected key frame, commits
// per-gate OBF select words, and locks out with key zeroization after repeated bad frames.
module obf_key_loader
  import obf_pkg::*;
#(
  parameter  int unsigned NUM_OBF  = 1,
  parameter  int unsigned MAX_FAIL = 3,
  localparam int unsigned KEY_W    = NUM_OBF * SEL_W,
  localparam int unsigned FCW      = $clog2(MAX_FAIL + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             load_abort,
  input  logic             sin_valid,
  input  logic             sin_data,
  output logic             sin_ready,
  output logic [KEY_W-1:0] key_sel,
  output logic             key_valid,
  output logic             busy,
  output logic             load_done,
  output logic             load_err,
  output logic             locked,
  output logic [FCW-1:0]   fail_cnt
);

  localparam logic [KEY_W-1:0] KEY_ZERO = {NUM_OBF{SEL_PASS}};

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             kv_q, kv_d;
  logic [FCW-1:0]   fail_q, fail_d, fail_inc;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, locked_q;
  logic             shadow_clr, shift_en;
  logic             full, parity_ok;
  logic [KEY_W-1:0] shadow_data;

  obf_key_shadow #(.KEY_W(KEY_W)) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (shadow_clr),
    .shift_en  (shift_en),
    .din       (sin_data),
    .full      (full),
    .parity_ok (parity_ok),
    .data      (shadow_data)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    kv_d       = kv_q;
    fail_d     = fail_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    shadow_clr = 1'b0;
    shift_en   = 1'b0;
    fail_inc   = (fail_q == FCW'(MAX_FAIL)) ? fail_q : fail_q + FCW'(1);
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d    = SHIFT;
          shadow_clr = 1'b1;
        end
      end
      SHIFT: begin
        if (load_abort) begin
          state_d = IDLE;
        end else if (sin_valid) begin
          shift_en = 1'b1;
          if (full) state_d = CHECK;
        end
      end
      CHECK: begin
        if (parity_ok) begin
          state_d = COMMIT;
        end else begin
          fail_d = fail_inc;
          err_d  = 1'b1;
          if (fail_inc == FCW'(MAX_FAIL)) begin
            state_d = LOCKED;
            key_d   = KEY_ZERO;
            kv_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        key_d   = shadow_data;
        kv_d    = 1'b1;
        fail_d  = '0;
        done_d  = 1'b1;
      end
      LOCKED: begin
        key_d = KEY_ZERO;
        kv_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; busy/locked are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      key_q    <= KEY_ZERO;
      kv_q     <= 1'b0;
      fail_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      kv_q     <= kv_d;
      fail_q   <= fail_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= (state_d != IDLE) && (state_d != LOCKED);
      locked_q <= (state_d == LOCKED);
    end
  end

  assign sin_ready = (state_q == SHIFT);
  assign key_sel   = key_q;
  assign key_valid = kv_q;
  assign fail_cnt  = fail_q;
  assign load_done = done_q;
  assign load_err  = err_q;
  assign busy      = busy_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_obf_key_loader.sv
// Self-checking bench: one loader with one gate and one with two gates, checked against
// a frame-level model (parity rule, failure counting, lockout, commit).
module tb_obf_key_loader;

  localparam int MAX_FAIL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_start, a_abort, a_valid, a_data;
  logic       a_ready, a_kv, a_busy, a_done, a_err, a_locked;
  logic [1:0] a_key;
  logic [1:0] a_fail;

  logic       b_start, b_abort, b_valid, b_data;
  logic       b_ready, b_kv, b_busy, b_done, b_err, b_locked;
  logic [3:0] b_key;
  logic [1:0] b_fail;

  obf_key_loader #(.NUM_OBF(1), .MAX_FAIL(MAX_FAIL)) dut_a (
    .clk(clk), .rst_n(rst_n), .load_start(a_start), .load_abort(a_abort),
    .sin_valid(a_valid), .sin_data(a_data), .sin_ready(a_ready), .key_sel(a_key),
    .key_valid(a_kv), .busy(a_busy), .load_done(a_done), .load_err(a_err),
    .locked(a_locked), .fail_cnt(a_fail)
  );

  obf_key_loader #(.NUM_OBF(2), .MAX_FAIL(MAX_FAIL)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_start(b_start), .load_abort(b_abort),
    .sin_valid(b_valid), .sin_data(b_data), .sin_ready(b_ready), .key_sel(b_key),
    .key_valid(b_kv), .busy(b_busy), .load_done(b_done), .load_err(b_err),
    .locked(b_locked), .fail_cnt(b_fail)
  );

  // Observed outputs per instance: ready,busy,done,err,locked,valid,fail[1:0],key[3:0]
  logic [11:0] obs [2];
  assign obs[0] = {a_ready, a_busy, a_done, a_err, a_locked, a_kv, a_fail, 2'b00, a_key};
  assign obs[1] = {b_ready, b_busy, b_done, b_err, b_locked, b_kv, b_fail, b_key};

  int checks = 0;
  int failures = 0;

  // Frame-level reference model
  logic [3:0] m_key [2];
  bit         m_kv [2];
  int         m_fail [2];
  bit         m_locked [2];

  function automatic int kw(int w);
    return (w == 0) ? 2 : 4;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(int w, bit s, bit ab, bit v, bit d);
    if (w == 0) begin
      a_start = s; a_abort = ab; a_valid = v; a_data = d;
    end else begin
      b_start = s; b_abort = ab; b_valid = v; b_data = d;
    end
  endtask

  task automatic chk(string tag, logic [3:0] o, logic [3:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic chk_all(int w, string tag, bit ready, bit busy, bit done, bit err);
    logic [11:0] o;
    o = obs[w];
    chk($sformatf("%s.u%0d.key", tag, w), o[3:0], m_key[w]);
    chk($sformatf("%s.u%0d.valid", tag, w), 4'(o[6]), 4'(m_kv[w]));
    chk($sformatf("%s.u%0d.fail", tag, w), 4'(o[5:4]), 4'(m_fail[w]));
    chk($sformatf("%s.u%0d.locked", tag, w), 4'(o[7]), 4'(m_locked[w]));
    chk($sformatf("%s.u%0d.ready", tag, w), 4'(o[11]), 4'(ready));
    chk($sformatf("%s.u%0d.busy", tag, w), 4'(o[10]), 4'(busy));
    chk($sformatf("%s.u%0d.done", tag, w), 4'(o[9]), 4'(done));
    chk($sformatf("%s.u%0d.err", tag, w), 4'(o[8]), 4'(err));
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    for (int w = 0; w < 2; w++) begin
      m_key[w] = '0; m_kv[w] = 1'b0; m_fail[w] = 0; m_locked[w] = 1'b0;
      chk_all(w, "reset", 0, 0, 0, 0);
    end
  endtask

  // One full frame: key bits then parity bit at index kw(w), LSB first.
  task automatic frame(int w, logic [4:0] bits, bit gaps);
    int  n;
    bit  p;
    bit  lk;
    n  = kw(w) + 1;
    lk = m_locked[w];
    drv(w, 1, 0, 0, 0);
    step();
    drv(w, 0, 0, 0, 0);
    if (lk) chk_all(w, "lk_start", 0, 0, 0, 0);
    else    chk_all(w, "start", 1, 1, 0, 0);
    p = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      drv(w, 0, 0, 1, bits[i]);
      p ^= bits[i];
      step();
      drv(w, 0, 0, 0, 0);
    end
    if (lk) begin
      step();
      step();
      chk_all(w, "lk_frame", 0, 0, 0, 0);
      return;
    end
    chk_all(w, "check", 0, 1, 0, 0);
    step();
    if (p) begin
      m_fail[w] = (m_fail[w] < MAX_FAIL) ? m_fail[w] + 1 : MAX_FAIL;
      if (m_fail[w] == MAX_FAIL) begin
        m_locked[w] = 1'b1; m_key[w] = '0; m_kv[w] = 1'b0;
      end
      chk_all(w, "bad", 0, 0, 0, 1);
      step();
      chk_all(w, "bad_after", 0, 0, 0, 0);
    end else begin
      chk_all(w, "commit", 0, 1, 0, 0);
      step();
      m_key[w]  = (w == 0) ? {2'b00, bits[1:0]} : bits[3:0];
      m_kv[w]   = 1'b1;
      m_fail[w] = 0;
      chk_all(w, "done", 0, 0, 1, 0);
      step();
      chk_all(w, "idle", 0, 0, 0, 0);
    end
  endtask

  // Start a frame, send k key bits, then assert abort together with a valid bit.
  task automatic abort_frame(int w, int k);
    if (m_locked[w]) return;
    drv(w, 1, 0, 0, 0);
    step();
    drv(w, 0, 0, 0, 0);
    for (int i = 0; i < k; i++) begin
      drv(w, 0, 0, 1, 1'($urandom));
      step();
    end
    drv(w, 0, 1, 1, 1'($urandom));
    step();
    drv(w, 0, 0, 0, 0);
    chk_all(w, "abort", 0, 0, 0, 0);
    step();
    chk_all(w, "abort_after", 0, 0, 0, 0);
  endtask

  initial begin
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    step();
    reset_all();

    // Good frame 0,1,1 -> SEL_INV
    frame(0, 5'b00110, 1'b0);
    chk("t2_key", 4'(a_key), 4'b0010);
    // Bad parity 1,0,0
    frame(0, 5'b00001, 1'b0);
    chk("t3_fail", 4'(a_fail), 4'd1);
    // Lockout after two more bad frames, then ignored start
    frame(0, 5'b00111, 1'b0);
    frame(0, 5'b00100, 1'b0);
    chk("t4_locked", 4'(a_locked), 4'd1);
    frame(0, 5'b00110, 1'b0);
    reset_all();

    // Gapped frame and aborts (mid-frame and on the parity bit)
    frame(0, 5'b00110, 1'b1);
    abort_frame(0, 1);
    abort_frame(0, 2);
    chk("t5_key", 4'(a_key), 4'b0010);

    // Reset mid-frame discards it
    drv(0, 1, 0, 0, 0);
    step();
    drv(0, 0, 0, 1, 1);
    step();
    reset_all();

    // Two-gate instance: two fails then 1,0,0,1,0
    frame(1, 5'b00001, 1'b0);
    frame(1, 5'b00111, 1'b1);
    frame(1, 5'b01001, 1'b0);
    chk("t6_key", b_key, 4'b1001);
    chk("t6_fail", 4'(b_fail), 4'd0);

    // Randomized frames against the model
    for (int it = 0; it < 60; it++) begin
      int w;
      w = int'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 2) abort_frame(w, int'($urandom_range(0, kw(w))));
      else frame(w, 5'($urandom), 1'($urandom));
      if (m_locked[0] || m_locked[1]) begin
        frame(m_locked[0] ? 0 : 1, 5'($urandom), 1'b0);
        reset_all();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
